// File: rtl/ldl_round_wrr.sv
// Weighted round-robin arbiter: holds a grant for up to weight[owner] accepted beats, then rotates.
// Latency: ack 1 cycle after a request in IDLE; handover to the next requester has no bubble.
// Backpressure: ready=0 freezes owner and credit; xfer = ack & ready is the accepted-beat strobe.
module ldl_round_wrr #(
  parameter int REQ_NUM   = 5,
  parameter int BIN_WIDTH = $clog2(REQ_NUM),
  parameter int WGT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             req,
  input  logic [REQ_NUM*WGT_WIDTH-1:0]   weight,
  input  logic                           ready,
  output logic                           ack,
  output logic [BIN_WIDTH-1:0]           bin,
  output logic [REQ_NUM-1:0]             hot,
  output logic                           xfer
);

  typedef enum logic {IDLE, GRANT} state_t;

  // One extra bit so start+offset never overflows before the wrap subtraction.
  localparam logic [BIN_WIDTH:0]   REQ_NUM_W = (BIN_WIDTH+1)'(REQ_NUM);
  localparam logic [BIN_WIDTH-1:0] LAST_IDX  = BIN_WIDTH'(REQ_NUM-1);

  state_t                 state;
  logic [BIN_WIDTH-1:0]   owner;
  logic [BIN_WIDTH-1:0]   ptr;
  logic [WGT_WIDTH-1:0]   credit;

  logic [WGT_WIDTH-1:0]   eff_w [REQ_NUM];
  logic [BIN_WIDTH-1:0]   ptr_nxt;
  logic                   idle_found;
  logic [BIN_WIDTH-1:0]   idle_win;
  logic                   rel_found;
  logic [BIN_WIDTH-1:0]   rel_win;
  logic                   rel_now;

  // A zero weight would starve the grant, so it is promoted to a single beat.
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_wgt
    assign eff_w[i] = (weight[i*WGT_WIDTH +: WGT_WIDTH] == '0) ? WGT_WIDTH'(1)
                                                              : weight[i*WGT_WIDTH +: WGT_WIDTH];
  end

  // First set request scanning upward from start, wrapping at REQ_NUM-1 (never through unused codes).
  function automatic logic [BIN_WIDTH:0] scan(input logic [BIN_WIDTH-1:0] start,
                                              input logic [REQ_NUM-1:0]   r);
    logic                 found;
    logic [BIN_WIDTH-1:0] win;
    logic [BIN_WIDTH:0]   pos;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      pos = {1'b0, start} + (BIN_WIDTH+1)'(k);
      if (pos >= REQ_NUM_W) pos = pos - REQ_NUM_W;
      if (!found && r[pos[BIN_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = pos[BIN_WIDTH-1:0];
      end
    end
    return {found, win};
  endfunction

  // Output decode: the grant is only visible while the owner still requests.
  always_comb begin
    ack        = (state == GRANT) && req[owner];
    xfer       = ack && ready;
    bin        = ack ? owner : '0;
    hot        = '0;
    hot[owner] = ack;
  end

  // Arbitration candidates: from ptr when idle, from owner+1 at release (owner ends up last).
  always_comb begin
    ptr_nxt                 = (owner == LAST_IDX) ? '0 : owner + BIN_WIDTH'(1);
    {idle_found, idle_win}  = scan(ptr, req);
    {rel_found, rel_win}    = scan(ptr_nxt, req);
    rel_now                 = (state == GRANT) &&
                              ((xfer && (credit == WGT_WIDTH'(1))) || !req[owner]);
  end

  // Grant FSM: take a grant, spend credit on accepted beats, hand over without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= '0;
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state  <= GRANT;
            owner  <= idle_win;
            credit <= eff_w[idle_win];
          end
        end
        GRANT: begin
          if (rel_now) begin
            ptr <= ptr_nxt;
            if (rel_found) begin
              owner  <= rel_win;
              credit <= eff_w[rel_win];
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            credit <= credit - WGT_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule
